// File: rtl/sb_param_cfg.sv
`default_nettype none
// ============================================================================
// Module   : sb_param_cfg
// Brief    : Fabric-edge switch block. Outer tracks are driven by configurable
//            muxes whose selects come from a ccff-loaded shadow register that
//            is copied into the active set only on an explicit commit.
// Revision : 1.0 - initial release
// ============================================================================
module sb_param_cfg #(
    parameter int CHAN_WIDTH = 9,
    parameter int NMUX       = 2,
    parameter int MUX_SIZE   = 2
) (
    input  logic                         prog_clk,
    input  logic                         pReset_n,
    input  logic                         ccff_head,
    input  logic                         cfg_shift_en,
    input  logic                         cfg_commit,
    output logic                         ccff_tail,
    input  logic [CHAN_WIDTH-1:0]        chany_top_in,
    input  logic [CHAN_WIDTH-1:0]        chanx_left_in,
    input  logic [NMUX*(MUX_SIZE-1)-1:0] top_pin_in,
    input  logic [NMUX*(MUX_SIZE-1)-1:0] left_pin_in,
    output logic [CHAN_WIDTH-1:0]        chany_top_out,
    output logic [CHAN_WIDTH-1:0]        chanx_left_out,
    output logic                         cfg_count_ok,
    output logic                         cfg_active_valid,
    output logic                         cfg_commit_err,
    output logic                         cfg_sel_err
);

    localparam int SEL_W = (MUX_SIZE > 2) ? $clog2(MUX_SIZE) : 1;
    localparam int TOTAL = 2 * NMUX * SEL_W;
    localparam int NPIN  = MUX_SIZE - 1;
    localparam int CNT_W = $clog2(TOTAL + 1);

    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    logic [TOTAL-1:0] r_shadow;
    logic [TOTAL-1:0] r_active;
    logic [CNT_W-1:0] r_count;
    logic             r_active_valid;
    logic             r_commit_err;
    logic             r_sel_err;

    logic             w_full;
    logic             w_commit_ok;

    // True when any select field in a configuration word names a missing input.
    function automatic logic any_bad_sel(input logic [TOTAL-1:0] cfg);
        logic        bad;
        logic [31:0] s;
        bad = 1'b0;
        for (int m = 0; m < 2 * NMUX; m++) begin
            s = 32'(cfg[m*SEL_W +: SEL_W]);
            if (s >= 32'(MUX_SIZE)) bad = 1'b1;
        end
        return bad;
    endfunction

    // Select 0 is the track, 1..NPIN are grid pins, anything larger drives 0.
    function automatic logic mux_pick(input logic [SEL_W-1:0] sel,
                                      input logic             trk,
                                      input logic [NPIN-1:0]  pins);
        logic        o;
        logic [31:0] s;
        s = 32'(sel);
        o = (s == 32'd0) ? trk : 1'b0;
        for (int p = 0; p < NPIN; p++) begin
            if (s == 32'(p + 1)) o = pins[p];
        end
        return o;
    endfunction

    assign w_full      = (r_count == c_cnt_full);
    assign w_commit_ok = cfg_commit & w_full;

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_shadow       <= '0;
            r_active       <= '0;
            r_count        <= '0;
            r_active_valid <= 1'b0;
            r_commit_err   <= 1'b0;
            r_sel_err      <= 1'b0;
        end else begin
            if (cfg_shift_en) begin
                r_shadow <= {r_shadow[TOTAL-2:0], ccff_head};
            end

            // Commit samples the pre-edge shadow even when a shift shares the edge.
            if (w_commit_ok) begin
                r_active       <= r_shadow;
                r_active_valid <= 1'b1;
                r_commit_err   <= 1'b0;
                r_sel_err      <= any_bad_sel(r_shadow);
            end else if (cfg_commit) begin
                r_commit_err   <= 1'b1;
            end

            if (w_commit_ok) begin
                r_count <= cfg_shift_en ? c_cnt_one : '0;
            end else if (cfg_shift_en && !w_full) begin
                r_count <= r_count + c_cnt_one;
            end
        end
    end

    assign ccff_tail        = r_shadow[TOTAL-1];
    assign cfg_count_ok     = w_full;
    assign cfg_active_valid = r_active_valid;
    assign cfg_commit_err   = r_commit_err;
    assign cfg_sel_err      = r_sel_err;

    // Top mux k sits at field 2*NMUX-1-k, left mux k at field NMUX-1-k.
    for (genvar k = 0; k < NMUX; k++) begin : g_mux
        localparam int TRK = (k % 2 == 0) ? (k / 2) : (CHAN_WIDTH - 1 - k / 2);

        assign chany_top_out[k]  = mux_pick(r_active[(2*NMUX-1-k)*SEL_W +: SEL_W],
                                            chanx_left_in[TRK],
                                            top_pin_in[k*NPIN +: NPIN]);
        assign chanx_left_out[k] = mux_pick(r_active[(NMUX-1-k)*SEL_W +: SEL_W],
                                            chany_top_in[TRK],
                                            left_pin_in[k*NPIN +: NPIN]);
    end

    for (genvar j = NMUX; j < CHAN_WIDTH; j++) begin : g_pass
        assign chany_top_out[j]  = chanx_left_in[CHAN_WIDTH-1-j+NMUX/2];
        assign chanx_left_out[j] = chany_top_in[CHAN_WIDTH-1-j+NMUX/2];
    end

endmodule
`default_nettype wire

// File: tb/tb_sb_param_cfg.sv
`default_nettype none
// Scoreboard bench for sb_param_cfg: a default instance (d0) and a
// MUX_SIZE=3 instance (d1) sharing clock, reset and channel inputs.
module tb_sb_param_cfg;

    logic prog_clk = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic       pReset_n;
    logic [8:0] lin, tin;

    logic       d0_head, d0_sh, d0_cm;
    logic [1:0] tp0, lp0;
    logic [8:0] d0_top, d0_left;
    logic       d0_tail, d0_ok, d0_valid, d0_cerr, d0_serr;

    logic       d1_head, d1_sh, d1_cm;
    logic [3:0] tp1, lp1;
    logic [8:0] d1_top, d1_left;
    logic       d1_tail, d1_ok, d1_valid, d1_cerr, d1_serr;

    logic [22:0] obs0;
    logic [21:0] obs1;
    assign obs0 = {d0_top, d0_left, d0_tail, d0_ok, d0_valid, d0_cerr, d0_serr};
    assign obs1 = {d1_top, d1_left, d1_ok, d1_valid, d1_cerr, d1_serr};

    sb_param_cfg #(.CHAN_WIDTH(9), .NMUX(2), .MUX_SIZE(2)) d0 (
        .prog_clk(prog_clk), .pReset_n(pReset_n),
        .ccff_head(d0_head), .cfg_shift_en(d0_sh), .cfg_commit(d0_cm),
        .ccff_tail(d0_tail),
        .chany_top_in(tin), .chanx_left_in(lin),
        .top_pin_in(tp0), .left_pin_in(lp0),
        .chany_top_out(d0_top), .chanx_left_out(d0_left),
        .cfg_count_ok(d0_ok), .cfg_active_valid(d0_valid),
        .cfg_commit_err(d0_cerr), .cfg_sel_err(d0_serr)
    );

    sb_param_cfg #(.CHAN_WIDTH(9), .NMUX(2), .MUX_SIZE(3)) d1 (
        .prog_clk(prog_clk), .pReset_n(pReset_n),
        .ccff_head(d1_head), .cfg_shift_en(d1_sh), .cfg_commit(d1_cm),
        .ccff_tail(d1_tail),
        .chany_top_in(tin), .chanx_left_in(lin),
        .top_pin_in(tp1), .left_pin_in(lp1),
        .chany_top_out(d1_top), .chanx_left_out(d1_left),
        .cfg_count_ok(d1_ok), .cfg_active_valid(d1_valid),
        .cfg_commit_err(d1_cerr), .cfg_sel_err(d1_serr)
    );

    logic [22:0] exp_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    // d0 reference state: active selects, bit count, flags, shifted-bit history
    int   e_sel[4];
    int   e_cnt;
    logic e_valid, e_cerr;
    logic shq[$];

    function automatic logic m_pick(input int s, input logic trk, input logic [3:0] pins,
                                    input int k, input int ms);
        if (s == 0) return trk;
        if (s < ms) return pins[k*(ms-1)+s-1];
        return 1'b0;
    endfunction

    function automatic logic [8:0] m_chan(input int sa, input int sb, input int ms,
                                          input logic [8:0] src, input logic [3:0] pins);
        logic [8:0] o;
        for (int j = 2; j < 9; j++) o[j] = src[9-j];
        o[0] = m_pick(sa, src[0], pins, 0, ms);
        o[1] = m_pick(sb, src[8], pins, 1, ms);
        return o;
    endfunction

    function automatic logic [22:0] exp0();
        logic t;
        t = (shq.size() >= 4) ? shq[shq.size()-4] : 1'b0;
        return {m_chan(e_sel[0], e_sel[1], 2, lin, {2'b00, tp0}),
                m_chan(e_sel[2], e_sel[3], 2, tin, {2'b00, lp0}),
                t, (e_cnt == 4), e_valid, e_cerr, 1'b0};
    endfunction

    function automatic logic [21:0] exp1(input int s0, input int s1, input int s2, input int s3);
        logic serr;
        serr = (s0 >= 3) || (s1 >= 3) || (s2 >= 3) || (s3 >= 3);
        return {m_chan(s0, s1, 3, lin, tp1), m_chan(s2, s3, 3, tin, lp1),
                1'b0, 1'b1, 1'b0, serr};
    endfunction

    task automatic model_reset();
        shq.delete();
        e_cnt   = 0;
        e_valid = 1'b0;
        e_cerr  = 1'b0;
        for (int m = 0; m < 4; m++) e_sel[m] = 0;
    endtask

    task automatic rand_io();
        lin = 9'($urandom);
        tin = 9'($urandom);
        tp0 = 2'($urandom);
        lp0 = 2'($urandom);
        tp1 = 4'($urandom);
        lp1 = 4'($urandom);
    endtask

    // Drive one d0 clock edge and push the state expected after it.
    task automatic step0(input logic h, input logic sh, input logic cm);
        d0_head = h;
        d0_sh   = sh;
        d0_cm   = cm;
        if (cm) begin
            if (e_cnt == 4) begin
                for (int m = 0; m < 4; m++) e_sel[m] = shq[shq.size()-4+m] ? 1 : 0;
                e_cnt   = 0;
                e_valid = 1'b1;
                e_cerr  = 1'b0;
            end else begin
                e_cerr  = 1'b1;
            end
        end
        if (sh) begin
            shq.push_back(h);
            if (e_cnt < 4) e_cnt++;
        end
        exp_q.push_back(exp0());
        @(posedge prog_clk);
        #1;
        d0_sh = 1'b0;
        d0_cm = 1'b0;
    endtask

    task automatic test_reset();
        logic [22:0] e;
        logic [21:0] e1;
        pReset_n = 1'b0;
        d0_head = 0; d0_sh = 0; d0_cm = 0;
        d1_head = 0; d1_sh = 0; d1_cm = 0;
        lin = 9'h155; tin = 9'h0F3;
        tp0 = 2'b10; lp0 = 2'b01; tp1 = 4'hA; lp1 = 4'h5;
        model_reset();
        #12;
        pReset_n = 1'b1;
        exp_q.push_back(exp0());
        #1;
        e = exp_q.pop_front(); n_chk++;
        if (obs0 !== e) begin
            n_fail++; $display("FAIL reset_d0: got %h expected %h", obs0, e);
        end
        e1 = {m_chan(0, 0, 3, lin, tp1), m_chan(0, 0, 3, tin, lp1), 4'b0000};
        n_chk++;
        if ({obs1, d1_tail} !== {e1, 1'b0}) begin
            n_fail++; $display("FAIL reset_d1: got %h expected %h", {obs1, d1_tail}, {e1, 1'b0});
        end
        for (int i = 0; i < 3; i++) begin
            rand_io();
            exp_q.push_back(exp0());
            #1;
            e = exp_q.pop_front(); n_chk++;
            if (obs0 !== e) begin
                n_fail++; $display("FAIL reset_pattern %0d: got %h expected %h", i, obs0, e);
            end
        end
    endtask

    task automatic test_good_load();
        logic [22:0] e;
        logic        bits[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        lin = 9'h1FF; tin = 9'h1FF; tp0 = 2'b00; lp0 = 2'b00;
        for (int i = 0; i < 5; i++) begin
            step0(bits[i], i < 4, i == 4);
            e = exp_q.pop_front(); n_chk++;
            if (obs0 !== e) begin
                n_fail++; $display("FAIL good_load step %0d: got %h expected %h", i, obs0, e);
            end
        end
        for (int i = 0; i < 4; i++) begin
            rand_io();
            exp_q.push_back(exp0());
            #1;
            e = exp_q.pop_front(); n_chk++;
            if (obs0 !== e) begin
                n_fail++; $display("FAIL good_load pattern %0d: got %h expected %h", i, obs0, e);
            end
        end
    endtask

    task automatic test_short_commit();
        logic [22:0] e;
        logic        bits[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        shs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        lin = 9'h1FF; tin = 9'h1FF; tp0 = 2'b00; lp0 = 2'b00;
        for (int i = 0; i < 6; i++) begin
            step0(bits[i], shs[i], !shs[i]);
            e = exp_q.pop_front(); n_chk++;
            if (obs0 !== e) begin
                n_fail++; $display("FAIL short_commit step %0d: got %h expected %h", i, obs0, e);
            end
        end
    endtask

    task automatic test_chain();
        logic [22:0] e;
        for (int i = 0; i < 12; i++) begin
            step0(1'($urandom), 1'b1, 1'b0);
            e = exp_q.pop_front(); n_chk++;
            if (obs0 !== e) begin
                n_fail++; $display("FAIL chain step %0d: got %h expected %h", i, obs0, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [22:0] e;
        step0(1'($urandom), 1'b1, 1'b1);
        e = exp_q.pop_front(); n_chk++;
        if (obs0 !== e) begin
            n_fail++; $display("FAIL shift_commit: got %h expected %h", obs0, e);
        end
        for (int i = 0; i < 3; i++) begin
            step0(1'($urandom), 1'b1, 1'b0);
            e = exp_q.pop_front(); n_chk++;
            if (obs0 !== e) begin
                n_fail++; $display("FAIL post_commit_count %0d: got %h expected %h", i, obs0, e);
            end
        end
    endtask

    task automatic test_sel_range();
        logic [22:0] e;
        int          ld[3][4] = '{'{3, 0, 0, 0}, '{2, 0, 0, 0}, '{1, 2, 3, 0}};
        for (int l = 0; l < 3; l++) begin
            lin = 9'h155; tin = 9'h1FF; tp1 = 4'b0101; lp1 = 4'b1010;
            for (int m = 0; m < 4; m++) begin
                for (int b = 1; b >= 0; b--) begin
                    d1_head = ((ld[l][m] >> b) & 1) != 0;
                    d1_sh   = 1'b1;
                    @(posedge prog_clk);
                    #1;
                end
            end
            d1_sh = 1'b0;
            d1_cm = 1'b1;
            exp_q.push_back({1'b0, exp1(ld[l][0], ld[l][1], ld[l][2], ld[l][3])});
            @(posedge prog_clk);
            #1;
            d1_cm = 1'b0;
            e = exp_q.pop_front(); n_chk++;
            if ({1'b0, obs1} !== e) begin
                n_fail++; $display("FAIL sel_range load %0d: got %h expected %h", l, obs1, e);
            end
            for (int i = 0; i < 3; i++) begin
                rand_io();
                exp_q.push_back({1'b0, exp1(ld[l][0], ld[l][1], ld[l][2], ld[l][3])});
                #1;
                e = exp_q.pop_front(); n_chk++;
                if ({1'b0, obs1} !== e) begin
                    n_fail++; $display("FAIL sel_range load %0d pattern %0d: got %h expected %h",
                                       l, i, obs1, e);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [22:0] e;
        lin = 9'h0AA; tin = 9'h155; tp0 = 2'b01; lp0 = 2'b10;
        for (int i = 0; i < 6; i++) begin
            step0(1'b1, i != 4, i == 4);
            e = exp_q.pop_front(); n_chk++;
            if (obs0 !== e) begin
                n_fail++; $display("FAIL async_preload step %0d: got %h expected %h", i, obs0, e);
            end
        end
        #3;
        pReset_n = 1'b0;
        model_reset();
        exp_q.push_back(exp0());
        #1;
        e = exp_q.pop_front(); n_chk++;
        if (obs0 !== e) begin
            n_fail++; $display("FAIL async_assert: got %h expected %h", obs0, e);
        end
        d0_head = 1'b1;
        d0_sh   = 1'b1;
        exp_q.push_back(exp0());
        @(posedge prog_clk);
        #1;
        e = exp_q.pop_front(); n_chk++;
        if (obs0 !== e) begin
            n_fail++; $display("FAIL held_in_reset: got %h expected %h", obs0, e);
        end
        d0_sh    = 1'b0;
        pReset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step0(1'b1, i < 3, i == 3);
            e = exp_q.pop_front(); n_chk++;
            if (obs0 !== e) begin
                n_fail++; $display("FAIL after_reset step %0d: got %h expected %h", i, obs0, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_load();
        test_short_commit();
        test_chain();
        test_back_to_back();
        test_sel_range();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sb_param_cfg.md
Name: sb_param_cfg

Overview:
- Parametrised switch block for the fabric edge. Each of the top and left sides has CHAN_WIDTH routing tracks.
- The outer track outputs on each side are driven by configurable MUX_SIZE-input muxes. The remaining tracks are fixed pass-throughs between the two sides.
- Configuration is loaded over the ccff daisy chain into a shadow shift register. It is moved into the active configuration only on an explicit commit, so reprogramming never glitches live routing.
- The block counts shifted bits and flags incomplete commits and out-of-range select codes.

Parameters:
- CHAN_WIDTH, 9: tracks per side. Must satisfy CHAN_WIDTH >= NMUX.
- NMUX, 2: muxed outputs per side. Must be even and >= 2.
- MUX_SIZE, 2: inputs per mux (1 track + MUX_SIZE-1 grid pins). Range 2..16.
- SEL_W, derived: max(1, clog2(MUX_SIZE)).
- TOTAL, derived: 2*NMUX*SEL_W, the number of config bits.

Ports:
- prog_clk  in  1  configuration clock
- pReset_n  in  1  asynchronous active-low reset
- ccff_head  in  1  serial config in
- cfg_shift_en  in  1  shift enable
- cfg_commit  in  1  copy shadow to active (single-cycle pulse)
- ccff_tail  out  1  serial config out, registered
- chany_top_in  in  CHAN_WIDTH  top-side incoming tracks
- chanx_left_in  in  CHAN_WIDTH  left-side incoming tracks
- top_pin_in  in  NMUX*(MUX_SIZE-1)  grid pins feeding the top muxes
- left_pin_in  in  NMUX*(MUX_SIZE-1)  grid pins feeding the left muxes
- chany_top_out  out  CHAN_WIDTH  top-side outgoing tracks
- chanx_left_out  out  CHAN_WIDTH  left-side outgoing tracks
- cfg_count_ok  out  1  at least TOTAL bits shifted since the last commit or reset
- cfg_active_valid  out  1  a successful commit has occurred
- cfg_commit_err  out  1  sticky: commit attempted while count was short
- cfg_sel_err  out  1  active configuration holds an out-of-range select

Behaviour:
- Clock and reset: single clock, prog_clk. pReset_n is asynchronous and active-low.
- Reset values:
  - shadow = 0, active = 0, bit counter = 0, ccff_tail = 0.
  - All flags = 0.
  - Every mux selects its track input (select 0). This is the safe default.
- Shift:
  - On each prog_clk rising edge with cfg_shift_en=1: shadow <= {shadow[TOTAL-2:0], ccff_head}.
  - ccff_tail always shows shadow[TOTAL-1], so a bit reaches the next block TOTAL edges later.
  - Shadow holds when cfg_shift_en=0.
- Bit map:
  - Muxes are indexed m = 0..NMUX-1 (top), then NMUX..2*NMUX-1 (left).
  - Mux m uses shadow[(2*NMUX-1-m)*SEL_W +: SEL_W].
  - The first SEL_W bits shifted in are top mux 0, MSB first.
- Counter:
  - Increments per shift and saturates at TOTAL. Over-shifting is legal because the chain continues downstream.
  - cfg_count_ok = (count == TOTAL).
- Commit (edge with cfg_commit=1):
  - If count == TOTAL: active <= shadow (the pre-edge value), count cleared, cfg_active_valid <= 1, cfg_commit_err <= 0, cfg_sel_err recomputed from the new active value.
  - Otherwise: active, count and cfg_sel_err are unchanged, and cfg_commit_err <= 1.
  - Shift and commit in the same cycle: the commit uses the pre-shift shadow and the shift still happens. After a good commit the count is then 1.
- Mux function (combinational from active, so new routing is visible right after the commit edge):
  - Select s=0 picks the track source; s in 1..MUX_SIZE-1 picks pin index s-1 of that mux's pin group (pins k*(MUX_SIZE-1) +: MUX_SIZE-1).
  - s >= MUX_SIZE drives 0 and sets cfg_sel_err at commit.
- Track sources:
  - Top mux k takes chanx_left_in[k/2] for even k, and chanx_left_in[CHAN_WIDTH-1-k/2] for odd k. It drives chany_top_out[k].
  - Left muxes mirror this with chany_top_in, driving chanx_left_out[k].
- Pass-through, for j = NMUX..CHAN_WIDTH-1:
  - chany_top_out[j] = chanx_left_in[CHAN_WIDTH-1-j+NMUX/2]
  - chanx_left_out[j] = chany_top_in[CHAN_WIDTH-1-j+NMUX/2]
- Reset mid-shift or mid-commit: everything returns to reset values immediately and asynchronously. The partial shadow is discarded.

Test Plan:
- Reset, defaults (CHAN_WIDTH=9, NMUX=2, MUX_SIZE=2, TOTAL=4):
  - Release pReset_n with chanx_left_in=9'h155 -> chany_top_out[0]=chanx_left_in[0], chany_top_out[1]=chanx_left_in[8], chany_top_out[8]=chanx_left_in[1].
  - All flags 0 and ccff_tail=0.
- Good load, defaults:
  - Shift 1,0,0,1 then commit -> top mux 0 selects top_pin_in[0], top mux 1 selects its track, left mux 0 selects its track, left mux 1 selects left_pin_in[1].
  - cfg_active_valid=1 and cfg_count_ok=0 after the commit edge.
- Short commit, defaults:
  - Shift 3 bits then commit -> outputs unchanged and cfg_commit_err=1.
  - Shift 1 more bit and commit -> new config applied and cfg_commit_err=0.
- Chain pass-through:
  - Shift 12 bits with cfg_shift_en=1 -> ccff_tail equals ccff_head delayed 4 edges, and the count saturates at 4.
- Out-of-range select (MUX_SIZE=3, SEL_W=2, TOTAL=8):
  - Load top mux 0 = 2'b11 and commit -> chany_top_out[0]=0 and cfg_sel_err=1.
  - Reload with 2'b10 -> chany_top_out[0] = top_pin_in[1] and cfg_sel_err=0.
- Simultaneous and reset cases:
  - Commit and shift on the same edge after a full load -> pre-shift shadow applied and count reads 1.
  - Assert pReset_n low between shift edges -> outputs revert to track defaults asynchronously.
